// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the MTM ALU serial link (serializer and deserializer).
// Holds the FSM state encoding, frame type bit values, CRC-3 polynomial,
// error-flag bit positions and the error payload builder.
package mtm_alu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_TYPE    = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_STOP    = 3'd4,
        ST_GAP     = 3'd5
    } state_t;

    localparam logic TYPE_DATA = 1'b0;
    localparam logic TYPE_CTRL = 1'b1;

    // x^3 + x + 1, x^3 term implicit
    localparam logic [2:0] CRC3_POLY = 3'b011;

    localparam int ERR_CRC_BIT  = 2;
    localparam int ERR_OP_BIT   = 1;
    localparam int ERR_DATA_BIT = 0;

    // Result packets carry data frames 0..3 and the control frame 4.
    localparam logic [2:0] LAST_RES_FRAME = 3'd4;

    // {1, e2, e2, e1, e1, e0, e0, parity over the upper seven bits}
    function automatic logic [7:0] err_payload(logic [2:0] e);
        logic [6:0] b;
        b = {1'b1, e[ERR_CRC_BIT], e[ERR_CRC_BIT], e[ERR_OP_BIT], e[ERR_OP_BIT],
             e[ERR_DATA_BIT], e[ERR_DATA_BIT]};
        return {b, ^b};
    endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// Request/serial-line bundle between the ALU side and the serializer.
//   res_valid, C_in[31:0], flags_in[3:0] : result request
//   err_valid, err_flags[2:0]            : error request
//   in_ready                             : serializer idle, request accepted
//   dout, busy                           : serial line and activity flag
interface mtm_alu_serializer_if;
    logic        res_valid;
    logic [31:0] C_in;
    logic [3:0]  flags_in;
    logic        err_valid;
    logic [2:0]  err_flags;
    logic        in_ready;
    logic        dout;
    logic        busy;

    modport master (
        output res_valid, C_in, flags_in, err_valid, err_flags,
        input  in_ready, dout, busy
    );

    modport slave (
        input  res_valid, C_in, flags_in, err_valid, err_flags,
        output in_ready, dout, busy
    );
endinterface

// File: rtl/mtm_alu_crc3.sv
// Combinational CRC-3 (x^3+x+1, init 0) over a 37-bit vector, MSB first.
//   data_i[36:0] : input vector
//   crc_o[2:0]   : remainder
module mtm_alu_crc3
    import mtm_alu_pkg::*;
(
    input  logic [36:0] data_i,
    output logic [2:0]  crc_o
);

    logic [2:0] crc;
    logic       fb;

    always_comb begin
        crc = 3'b000;
        fb  = 1'b0;
        for (int i = 36; i >= 0; i--) begin
            fb  = crc[2] ^ data_i[i];
            crc = {crc[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
        end
        crc_o = crc;
    end

endmodule

// File: rtl/mtm_alu_serializer.sv
// Serializes ALU results (4 data frames + 1 control frame with flags/CRC)
// or error reports (1 control frame) onto a single idle-high line.
//   clk, rst : system clock, async active-high reset
//   bus      : slave side of mtm_alu_serializer_if
//
// state   | meaning
// IDLE    | in_ready high, waiting for a request
// START   | driving start bit 0
// TYPE    | driving frame type bit
// PAYLOAD | driving payload bits MSB first, bit_cnt counts 0..7
// STOP    | driving stop bit 1, then next frame or GAP
// GAP     | one idle bit after the packet
module mtm_alu_serializer
    import mtm_alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mtm_alu_serializer_if.slave  bus
);

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  frame_cnt_q, frame_cnt_d;
    logic        is_err_q, is_err_d;
    logic [31:0] c_q, c_d;
    logic [3:0]  flags_q, flags_d;
    logic [2:0]  err_q, err_d;
    logic        dout_q, dout_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;

    logic        accept;
    logic        last_frame;
    logic        frame_type;
    logic [7:0]  payload;
    logic [2:0]  bit_nx;
    logic [2:0]  crc;

    mtm_alu_crc3 u_crc3 (
        .data_i ({c_q, 1'b0, flags_q}),
        .crc_o  (crc)
    );

    always_comb begin
        if (is_err_q) begin
            payload = err_payload(err_q);
        end else begin
            case (frame_cnt_q)
                3'd0:    payload = c_q[31:24];
                3'd1:    payload = c_q[23:16];
                3'd2:    payload = c_q[15:8];
                3'd3:    payload = c_q[7:0];
                default: payload = {1'b0, flags_q, crc};
            endcase
        end
        last_frame = is_err_q || (frame_cnt_q == LAST_RES_FRAME);
        frame_type = last_frame ? TYPE_CTRL : TYPE_DATA;
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        is_err_d    = is_err_q;
        c_d         = c_q;
        flags_d     = flags_q;
        err_d       = err_q;
        dout_d      = 1'b1;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        accept      = in_ready_q && (bus.res_valid || bus.err_valid);
        bit_nx      = bit_cnt_q + 3'd1;

        // dout_d is the bit for the state being entered, so dout stays registered.
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_START;
                    is_err_d    = bus.err_valid;
                    c_d         = bus.C_in;
                    flags_d     = bus.flags_in;
                    err_d       = bus.err_flags;
                    frame_cnt_d = 3'd0;
                    bit_cnt_d   = 3'd0;
                    dout_d      = 1'b0;
                    in_ready_d  = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_TYPE;
                dout_d  = frame_type;
            end
            ST_TYPE: begin
                state_d   = ST_PAYLOAD;
                bit_cnt_d = 3'd0;
                dout_d    = payload[7];
            end
            ST_PAYLOAD: begin
                bit_cnt_d = bit_nx;
                if (bit_cnt_q == 3'd7) begin
                    state_d = ST_STOP;
                    dout_d  = 1'b1;
                end else begin
                    dout_d = payload[3'd7 - bit_nx];
                end
            end
            ST_STOP: begin
                if (last_frame) begin
                    state_d = ST_GAP;
                    dout_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d     = ST_START;
                    frame_cnt_d = frame_cnt_q + 3'd1;
                    dout_d      = 1'b0;
                end
            end
            ST_GAP: begin
                state_d     = ST_IDLE;
                frame_cnt_d = 3'd0;
                in_ready_d  = 1'b1;
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            frame_cnt_q <= 3'd0;
            is_err_q    <= 1'b0;
            c_q         <= 32'd0;
            flags_q     <= 4'd0;
            err_q       <= 3'd0;
            dout_q      <= 1'b1;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            is_err_q    <= is_err_d;
            c_q         <= c_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            dout_q      <= dout_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;

endmodule

// File: doc/mtm_alu_serializer.md
MTM_ALU_SERIALIZER -- requirements
Module: mtm_Alu_serializer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-002 clk  input  1  rising-edge system clock; one serial bit per cycle.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 res_valid  input  1  result word available on C_in/flags_in.
REQ-005 C_in  input  32  ALU result.
REQ-006 flags_in  input  4  ALU flags {carry, overflow, zero, negative}.
REQ-007 err_valid  input  1  error report available on err_flags.
REQ-008 err_flags  input  3  {crc_err, op_err, data_err}.
REQ-009 in_ready  output  1  high only in IDLE; a request is accepted on a cycle with in_ready and res_valid or err_valid.
REQ-010 dout  output  1  serial line, idle high.
REQ-011 busy  output  1  high while any packet bit is being driven.

Function
REQ-012 Frame format, one bit per clk: start 0, type bit (0 data, 1 control), 8 payload bits MSB first, stop 1; 11 cycles per frame.
REQ-013 Result packet: 4 data frames C_in[31:24], [23:16], [15:8], [7:0], then 1 control frame with payload {0, flags[3:0], crc[2:0]}; 55 cycles, frames back-to-back with no gap.
REQ-014 crc[2:0] SHALL be CRC-3, polynomial x^3+x+1, init 3'b000, over the 37-bit vector {C[31:0], 1'b0, flags[3:0]}, MSB first.
REQ-015 Error packet: one control frame with payload {1, e2, e2, e1, e1, e0, e0, p}, where e = err_flags and p = XOR of payload bits [7:1]; 11 cycles.
REQ-016 If err_valid and res_valid are both high on an accept cycle, only the error packet SHALL be sent and the result SHALL be dropped.
REQ-017 Inputs SHALL be latched on accept; input changes during a packet SHALL have no effect.
REQ-018 The start bit SHALL appear on dout in the cycle after accept (latency 1).
REQ-019 FSM states: IDLE, START, TYPE, PAYLOAD, STOP, GAP.
REQ-020 Transitions: IDLE->START on accept; START->TYPE; TYPE->PAYLOAD; PAYLOAD->PAYLOAD for 8 bits via a 3-bit bit counter that wraps 7->0; PAYLOAD->STOP; STOP->START while frames remain, else STOP->GAP; GAP->IDLE.
REQ-021 A 3-bit frame counter SHALL select the frame: 0..3 data, 4 control for results; 0 only for errors.
REQ-022 GAP SHALL hold dout=1 for exactly one cycle so that packets are separated by at least one idle bit.
REQ-023 in_ready SHALL be low from accept until the GAP->IDLE transition.
REQ-024 busy SHALL be high in START, TYPE, PAYLOAD and STOP.
REQ-025 dout, in_ready and busy SHALL be registered outputs with no combinational path from the inputs.

Reset
REQ-026 On rst assertion, immediately: state=IDLE, dout=1, in_ready=1, busy=0, counters=0, latched data=0.
REQ-027 If rst is asserted mid-packet, the packet SHALL be aborted with no completion, and dout SHALL return to 1 at once.
REQ-028 The first accept SHALL be possible on the first clk edge after rst deasserts.

Structure
REQ-029 A shared package (mtm_Alu_pkg) SHALL hold the FSM state encoding, the frame type bit values, the CRC-3 polynomial, and the error-flag bit positions; the same package is reused by the deserializer.
REQ-030 The CRC-3 logic SHALL be a separate combinational sub-module, mtm_Alu_crc3 (37-bit data in, 3-bit CRC out), instantiated once.

Verification
REQ-031 C_in=0x00000000, flags_in=0 -> dout carries 4x "0 0 00000000 1" then "0 1 00000000 1" (crc=000); busy high for 55 cycles.
REQ-032 C_in=0xA5000000, flags_in=4'b0001 -> first frame payload 10100101, next three frames 0x00, control payload {0,0001,crc} with crc matching the reference model.
REQ-033 err_flags=3'b100 -> control payload 0xE1; 3'b010 -> 0x99; 3'b001 -> 0x87; each packet 11 cycles.
REQ-034 err_valid and res_valid both high on the same accept cycle -> only the error frame is sent; in_ready returns high 12 cycles after accept.
REQ-035 rst asserted during frame 2 of a result packet -> dout=1 immediately, in_ready=1, and the next request is transmitted correctly from its start bit.
REQ-036 Back-to-back requests held valid -> exactly one dout=1 GAP cycle between packets, and every bit matches a scoreboard that decodes the frames.
